chan_out_serializer: RTL
========================

Name: chan_out_serializer

Overview:
Receive-side companion to the channel interpolation model.
- Each emulator step, captures the model's four parallel signed fixed-point outputs, out_0..out_3. These are interpolated channel samples at sub-step offsets 0..3.
- Buffers the captured groups and emits them as an ordered scalar stream on a valid/ready handshake to the downstream analysis/CDR logic.
- The emulator cannot stall, so any group arriving while the buffer is full is dropped and counted.

Parameters:
WIDTH, 16, bit width of each signed fixed-point sample (same scaling as the model outputs).
DEPTH, 4, number of 4-sample groups buffered; power of two, >= 2.
DROP_W, 16, width of the saturating drop counter.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  out_0..out_3 hold a new group this cycle.
out_0  input  WIDTH  signed sample, sub-step offset 0.
out_1  input  WIDTH  signed sample, sub-step offset 1.
out_2  input  WIDTH  signed sample, sub-step offset 2.
out_3  input  WIDTH  signed sample, sub-step offset 3.
in_ready  output  1  buffer not full; advisory only, never stalls the model.
sample  output  WIDTH  current head sample.
sample_idx  output  2  sub-step offset of sample (0..3).
sample_valid  output  1  sample/sample_idx valid.
sample_ready  input  1  downstream accepts sample this cycle.
sample_bit  output  1  sliced decision (see Optional Feature).
drop_count  output  DROP_W  number of groups dropped since reset, saturating.
level  output  $clog2(DEPTH)+1  number of groups currently held (including partially emitted head).

Behaviour:
Reset (rst=1 at a clock edge):
- Pointers, sub-index, level and drop_count clear to 0.
- sample_valid=0, sample_idx=0, sample=0, sample_bit=0, in_ready=1.
- Reset mid-group discards all buffered data. No partial group is emitted afterwards.

Storage:
- Circular buffer of DEPTH entries, each holding {out_0,out_1,out_2,out_3}.
- Write pointer, read pointer and sub-index (2 bits) are all registered.

Push:
- in_ready = (level != DEPTH), combinational from the registered level.
- Condition: in_valid && in_ready. Writes all four samples at the write pointer and increments it, wrapping at DEPTH.

Drop:
- Condition: in_valid && !in_ready.
- Data is discarded, drop_count increments, saturating at 2^DROP_W-1.
- Buffer contents are unchanged.

Output (no combinational path from in_* to sample*):
- sample_valid = (level != 0).
- sample = head entry's element [sub-index]; sample_idx = sub-index.
- A beat transfers on sample_valid && sample_ready. Each beat increments the sub-index.
- On the beat with sub-index=3: sub-index wraps to 0 and the read pointer advances, i.e. the group is popped.
- sample/sample_idx must hold stable while sample_valid && !sample_ready.

Latency and throughput:
- A group pushed at edge t is visible on sample at cycle t+1, with sample_idx=0.
- Sustained throughput is one sample per clock, so a group drains in 4 beats.

Simultaneous push and pop:
- Same edge: level unchanged.
- Full and popping in the same cycle: still a drop, because in_ready is computed from the registered level. There is no bypass.

Ordering:
- Groups leave in arrival order.
- Samples within a group leave in order 0,1,2,3.

Optional Feature:
Macro: CHAN_OUT_SLICER_EN
- Defined: sample_bit = 1 when sample >= 0 (signed, i.e. MSB=0), else 0. Combinational from sample, qualified by sample_valid; sample_bit=0 when !sample_valid.
- Not defined: sample_bit is tied to 0; no slicer logic is generated.
- The port exists in both builds.

Test Plan:
1. Reset then single group: push {100,-200,300,-400}, sample_ready=1 -> outputs 100,-200,300,-400 with idx 0,1,2,3 on cycles t+1..t+4; then sample_valid=0, level back to 0.
2. Backpressure: push one group, sample_ready=0 for 5 cycles -> sample=100, idx=0 held stable; then ready=1 -> remaining samples in order, no duplicates.
3. Overflow with DEPTH=4: sample_ready=0, in_valid=1 for 6 cycles with distinct groups -> in_ready=0 after 4 pushes, drop_count=2, level=4; draining yields exactly the first 4 groups in order (16 beats).
4. Full plus pop in the same cycle: buffer full, head at idx=3 with ready=1 and in_valid=1 -> drop_count increments by 1, level goes 4->3.
5. Reset mid-operation: 3 groups buffered, head at idx=2, rst=1 for one cycle -> next cycle sample_valid=0, level=0, drop_count=0, in_ready=1; a new group emits from idx 0.
6. With CHAN_OUT_SLICER_EN defined: stream {5,-1,0,-32768} -> sample_bit 1,0,1,0. Without the macro -> sample_bit constantly 0.

Source files
------------

// File: rtl/chan_out_serializer.sv
// Buffers 4-sample groups from the channel interpolation model and streams them out one sample per beat.
// Optional slicer on the output sample is enabled by defining CHAN_OUT_SLICER_EN.
module chan_out_serializer #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [WIDTH-1:0]    out_0,
  input  logic signed [WIDTH-1:0]    out_1,
  input  logic signed [WIDTH-1:0]    out_2,
  input  logic signed [WIDTH-1:0]    out_3,
  output logic                       in_ready,
  output logic signed [WIDTH-1:0]    sample,
  output logic [1:0]                 sample_idx,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       sample_bit,
  output logic [DROP_W-1:0]          drop_count,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef logic [3:0][WIDTH-1:0] grp_t;

  grp_t          mem [DEPTH];
  grp_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    sub;
  logic          push, drop, beat, pop;

  assign in_ready     = (level != FULL);
  assign sample_valid = (level != '0);
  assign push = in_valid && in_ready;
  assign drop = in_valid && !in_ready;
  assign beat = sample_valid && sample_ready;
  assign pop  = beat && (sub == 2'd3);

  // Output is driven only from registered state, so no in_* -> sample* path.
  assign head       = mem[rd_ptr];
  assign sample     = sample_valid ? head[sub] : '0;
  assign sample_idx = sub;

`ifdef CHAN_OUT_SLICER_EN
  assign sample_bit = sample_valid && !sample[WIDTH-1];
`else
  assign sample_bit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {out_3, out_2, out_1, out_0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sub        <= '0;
      level      <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (beat) sub <= sub + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule
